// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
// FSM state encoding, op codes and flag bit positions.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/serial_full_adder.sv
// One-bit full adder with optional inversion of the b input.
// Inverting b while seeding carry-in with 1 turns each add step into a subtract step.
module serial_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic inv,
    output logic s,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ inv;
    assign s     = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one bit per clock LSB-first, start/done handshake.
// Optional {N,Z,V} flags output is built when SERIAL_ADDSUB_FLAGS_EN is defined.
//
// Handshake: start is sampled only when not busy (IDLE or DONE); an accepted start
// captures op/a/b, busy is high for exactly WIDTH cycles, then done pulses for one
// cycle with result/carry_out valid, and they stay held until the next result.
module serial_addsub
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ADDSUB_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             op_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             fa_s;
    logic             fa_cout;

    assign accept   = start && (state == IDLE || state == DONE);
    assign last     = (state == SHIFT) && (cnt == LAST);
    assign res_next = {fa_s, res_sh};
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    serial_full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .inv  (op_r),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_r      <= OP_ADD;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            op_r  <= op;
            carry <= op;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[WIDTH-1:1];
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                result    <= res_next;
                carry_out <= fa_cout;
            end
        end
    end

`ifdef SERIAL_ADDSUB_FLAGS_EN
    // On the last bit the carry register still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (last) begin
            flags[FLAG_N] <= fa_s;
            flags[FLAG_Z] <= (res_next == '0);
            flags[FLAG_V] <= carry ^ fa_cout;
        end
    end
`endif

endmodule
